bram_scale_engine: RTL
======================

// Module: bram_scale_engine
// PURPOSE
//  Parametrised BRAM-to-BRAM scaler, the next generation of the single-width BRAM multiplier.
//  - Reads LEN words from the input BRAM and computes y = (x * COEF) >>> SHIFT.
//  - Writes each result to the same index in the output BRAM.
//  - Controlled over AXI4-Lite. Adds signed mode, a post-multiply shift and a busy/done status.
//  - Sits between the PS AXI GP port and two dual-port BRAMs; the PS owns the other BRAM ports.
// PARAMETERS
//  DATA_W      32   sample width, input and output BRAM
//  COEF_W      16   coefficient width
//  DEPTH       256  max words per run; LEN is clamped to DEPTH
//  BRAM_ADDR_W 32   BRAM byte-address width; word i is at byte address 4*i
//  AXI_ADDR_W  4    AXI-Lite address width
// PORTS
//  clk            in   1            clock
//  rst_n          in   1            reset, synchronous, active-low
//  s_axi_aw*/w*/b*/ar*/r*  AXI4-Lite slave, 32-bit data, AXI_ADDR_W address, standard directions
//  in_bram_addr   out  BRAM_ADDR_W  input BRAM read address
//  in_bram_en     out  1            input BRAM enable
//  in_bram_dout   in   DATA_W       input BRAM read data, 1-cycle latency
//  out_bram_addr  out  BRAM_ADDR_W  output BRAM write address
//  out_bram_din   out  DATA_W       output BRAM write data
//  out_bram_we    out  4            output BRAM byte write enables: 4'hF on write, else 0
//  irq            out  1            level interrupt, equals STATUS.DONE
// BEHAVIOUR
//  Reset: all outputs 0, registers 0, FSM in IDLE, no BRAM write issued.
//  Register map:
//   0x0 CTRL:   [15:0] LEN (words); [16] START (W1, self-clearing, reads 0); [17] SIGNED
//   0x4 COEF:   [COEF_W-1:0]
//   0x8 SHIFT:  [5:0] arithmetic right shift applied to the product
//   0xC STATUS: [0] BUSY (RO); [1] DONE (sticky, W1C); [2] SAT (sticky, W1C)
//   Unmapped address: write ignored, read returns 0. All responses are OKAY.
//  AXI-Lite handshake:
//   - AW and W are accepted independently and in either order, one beat each; the address is latched.
//   - The register write happens once both are held; bvalid rises the next cycle and is held until bready.
//   - No new AW or W is accepted while bvalid is high.
//   - AR is accepted when rvalid=0; rvalid rises the next cycle and is held until rready.
//   - wstrb is ignored; a full-word write is always performed.
//  Writes to CTRL, COEF and SHIFT while BUSY are ignored, except DONE/SAT W1C in STATUS.
//  FSM:
//   IDLE  -> START=1: latch cfg, idx=0, BUSY=1, clear DONE; go to RUN; LEN=0 goes to FIN
//   RUN   -> issue one read per cycle (in_bram_en=1); after read LEN-1 go to DRAIN
//   DRAIN -> wait until the last write retires, then go to FIN
//   FIN   -> BUSY=0, DONE=1, go to IDLE
//  Pipeline: read addr (c0) -> dout valid (c1) -> product reg (c2) -> shift/sat, write (c3).
//   Throughput 1 word/cycle; a run takes LEN+4 cycles from the START write to DONE.
//  Arithmetic:
//   - Full product of DATA_W+COEF_W bits, signed or unsigned per SIGNED.
//   - Arithmetic shift (logical shift when unsigned), then reduced to DATA_W (see CONFIGURATION).
//  START while BUSY: ignored, with no effect on the current run.
//  Reset during a run: the run aborts in the same cycle; write enables go low; DONE stays 0.
// CONFIGURATION
//  SCALE_SAT_EN defined:
//   - Out-of-range results clamp to the DATA_W max/min (signed) or all-ones (unsigned).
//   - STATUS.SAT is set on any clamp.
//  SCALE_SAT_EN undefined:
//   - Results are truncated to the low DATA_W bits.
//   - STATUS.SAT reads 0 and its logic is removed.
// TESTING
//  1 Input words 4,8..32; COEF=25, SHIFT=0, LEN=8, start -> output 100,200..800; DONE=1; STATUS read 0x2.
//  2 Rerun with COEF=10 -> output 40..320; DONE is cleared at start and set again at the end.
//  3 SIGNED=1, COEF=-3 (0xFFFD), input 4, LEN=1 -> output 0xFFFFFFF4.
//  4 Input 0x7FFFFFFF, COEF=2, SIGNED=1 -> SAT_EN: output 0x7FFFFFFF, SAT=1; without: output 0xFFFFFFFE.
//  5 LEN=0, start -> DONE within 2 cycles, out_bram_we stays 0; second START while BUSY -> LEN+4 timing unchanged.
//  6 rst_n low for 1 cycle mid-run (LEN=8) -> outputs 0 next edge, BUSY=0, DONE=0, no further writes.

Source files
------------

// File: rtl/bram_scale_engine.sv
// bram_scale_engine: AXI-Lite controlled BRAM-to-BRAM scaler y=(x*COEF)>>>SHIFT, define SCALE_SAT_EN for saturation
module bram_scale_engine #(
  parameter int DATA_W      = 32,
  parameter int COEF_W      = 16,
  parameter int DEPTH       = 256,
  parameter int BRAM_ADDR_W = 32,
  parameter int AXI_ADDR_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AXI_ADDR_W-1:0]  s_axi_awaddr,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [31:0]            s_axi_wdata,
  input  logic [3:0]             s_axi_wstrb,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [AXI_ADDR_W-1:0]  s_axi_araddr,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [31:0]            s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic [BRAM_ADDR_W-1:0] in_bram_addr,
  output logic                   in_bram_en,
  input  logic [DATA_W-1:0]      in_bram_dout,
  output logic [BRAM_ADDR_W-1:0] out_bram_addr,
  output logic [DATA_W-1:0]      out_bram_din,
  output logic [3:0]             out_bram_we,
  output logic                   irq
);
  localparam int PW = DATA_W + COEF_W;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_FIN = 2'd3;
  logic [1:0] state, wsel, rsel;
  logic live, aw_held, w_held, busy, wr_fire, start, sgn, done, sat, v1, v2, unused_ok;
  logic [AXI_ADDR_W-1:0] wa;
  logic [31:0] wd, rd;
  logic [15:0] len_reg, len_r, len_c, idx, a1, a2;
  logic [COEF_W-1:0] coef;
  logic [5:0] shift;
  logic [PW-1:0] x_ext, c_ext, mul, prod, sh;
  logic signed [PW-1:0] sh_s;
  logic [DATA_W-1:0] res;
`ifdef SCALE_SAT_EN
  logic clamp;
`endif
  always_comb begin
    busy = state != S_IDLE;
    wr_fire = aw_held && w_held;
    wsel = wa[3:2];
    rsel = s_axi_araddr[3:2];
    start = wr_fire && wsel == 2'd0 && wd[16] && !busy;
    len_c = wd[15:0] > 16'(DEPTH) ? 16'(DEPTH) : wd[15:0];
    x_ext = sgn ? {{COEF_W{in_bram_dout[DATA_W-1]}}, in_bram_dout} : {{COEF_W{1'b0}}, in_bram_dout};
    c_ext = sgn ? {{DATA_W{coef[COEF_W-1]}}, coef} : {{DATA_W{1'b0}}, coef};
    mul = x_ext * c_ext;
    sh_s = $signed(prod) >>> shift;
    sh = sgn ? $unsigned(sh_s) : prod >> shift;
`ifdef SCALE_SAT_EN
    clamp = sgn ? sh[PW-1:DATA_W-1] != {(PW-DATA_W+1){sh[PW-1]}} : sh[PW-1:DATA_W] != '0;
    res = !clamp ? sh[DATA_W-1:0] : !sgn ? '1 :
          sh[PW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`else
    res = sh[DATA_W-1:0];
`endif
    rd = rsel == 2'd0 ? {14'd0, sgn, 1'b0, len_reg} : rsel == 2'd1 ? 32'(coef) :
         rsel == 2'd2 ? {26'd0, shift} : {29'd0, sat, done, busy};
  end
  assign s_axi_awready = live && !aw_held && !s_axi_bvalid;
  assign s_axi_wready = live && !w_held && !s_axi_bvalid;
  assign s_axi_arready = live && !s_axi_rvalid;
  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;
  assign in_bram_en = state == S_RUN;
  assign in_bram_addr = BRAM_ADDR_W'({idx, 2'b00});
  assign irq = done;
  assign unused_ok = ^{s_axi_wstrb, s_axi_awaddr, s_axi_araddr, wa, wd, sh};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live <= 1'b0;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      wa <= '0;
      wd <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata <= '0;
      len_reg <= '0;
      sgn <= 1'b0;
      coef <= '0;
      shift <= '0;
    end else begin
      live <= 1'b1;
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held <= 1'b1;
        wa <= s_axi_awaddr;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held <= 1'b1;
        wd <= s_axi_wdata;
      end
      if (wr_fire) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
        s_axi_bvalid <= 1'b1;
      end else if (s_axi_bready) s_axi_bvalid <= 1'b0;
      if (wr_fire && !busy && wsel == 2'd0) begin
        len_reg <= wd[15:0];
        sgn <= wd[17];
      end
      if (wr_fire && !busy && wsel == 2'd1) coef <= wd[COEF_W-1:0];
      if (wr_fire && !busy && wsel == 2'd2) shift <= wd[5:0];
      if (s_axi_arvalid && s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata <= rd;
      end else if (s_axi_rready) s_axi_rvalid <= 1'b0;
    end
  end
  // v1/v2 track which pipeline stages hold a live word; DRAIN ends once both are empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx <= '0;
      len_r <= '0;
      done <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      a1 <= '0;
      a2 <= '0;
      prod <= '0;
      out_bram_we <= 4'h0;
      out_bram_addr <= '0;
      out_bram_din <= '0;
    end else begin
      if (start) begin
        idx <= '0;
        len_r <= len_c;
        state <= len_c == '0 ? S_FIN : S_RUN;
      end else if (state == S_RUN) begin
        idx <= idx + 16'd1;
        if (idx == len_r - 16'd1) state <= S_DRAIN;
      end else if (state == S_DRAIN) begin
        if (!v1 && !v2) state <= S_FIN;
      end else if (state == S_FIN) state <= S_IDLE;
      done <= start ? 1'b0 : state == S_FIN ? 1'b1 : (wr_fire && wsel == 2'd3 && wd[1]) ? 1'b0 : done;
      v1 <= in_bram_en;
      v2 <= v1;
      a1 <= idx;
      a2 <= a1;
      prod <= mul;
      out_bram_we <= v2 ? 4'hF : 4'h0;
      if (v2) begin
        out_bram_addr <= BRAM_ADDR_W'({a2, 2'b00});
        out_bram_din <= res;
      end
    end
  end
`ifdef SCALE_SAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) sat <= 1'b0;
    else sat <= (v2 && clamp) ? 1'b1 : (wr_fire && wsel == 2'd3 && wd[2]) ? 1'b0 : sat;
  end
`else
  assign sat = 1'b0;
`endif
endmodule
